qos_wrr_arbiter: RTL and testbench
==================================

QOS_WRR_ARBITER -- requirements
Module: qos_wrr_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have parameter WW, default 4, meaning per-port weight width.
REQ-004 SHALL have port sys_clk  in  1  system clock; all logic on its rising edge (single clock).
REQ-005 SHALL have port sys_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  NPORTS  per-port beat valid.
REQ-007 SHALL have port req_last  in  NPORTS  per-port last beat of burst.
REQ-008 SHALL have port req_we  in  NPORTS  per-port write flag.
REQ-009 SHALL have port req_addr  in  NPORTS*AW  per-port address, port i at bits [i*AW +: AW].
REQ-010 SHALL have port req_ready  out  NPORTS  per-port beat accept.
REQ-011 SHALL have port weight  in  NPORTS*WW  per-port credit reload value, port i at [i*WW +: WW].
REQ-012 SHALL have port mem_valid  out  1  beat valid to memory.
REQ-013 SHALL have port mem_ready  in  1  memory accepts beat.
REQ-014 SHALL have port mem_addr  out  AW  muxed address.
REQ-015 SHALL have port mem_we  out  1  muxed write flag.
REQ-016 SHALL have port mem_port  out  clog2(NPORTS)  index of granted port.
REQ-017 SHALL have port grant  out  NPORTS  one-hot current grant, zero when none.
REQ-018 SHALL have port served_cnt  out  NPORTS*32  per-port completed-burst counters.

Function
REQ-019 SHALL implement FSM states IDLE, REFILL, BURST.
REQ-020 Eligible set SHALL be req_valid & (credit != 0); credit is a WW-bit register per port.
REQ-021 IDLE: if eligible nonzero, SHALL pick first eligible port scanning from rr_ptr upward with wrap, register grant/mem_port, go BURST next cycle.
REQ-022 IDLE: if eligible zero and req_valid nonzero, SHALL go REFILL; if req_valid zero, SHALL stay IDLE.
REQ-023 REFILL: SHALL load every credit from weight, a weight of 0 loading 1, then return to IDLE (one cycle).
REQ-024 BURST: mem_valid, mem_addr, mem_we SHALL combinationally follow the granted port; req_ready[g] = mem_ready, other req_ready bits 0.
REQ-025 Beat handshake SHALL be mem_valid & mem_ready; non-last beats keep BURST.
REQ-026 Handshake with req_last[g]=1 SHALL, on that edge: decrement credit[g], increment served_cnt[g] saturating at 0xFFFFFFFF, set rr_ptr = (g+1) mod NPORTS, clear grant, go IDLE.
REQ-027 Grant SHALL be held through the whole burst even if req_valid[g] drops (mem_valid then 0); no preemption.
REQ-028 Minimum latency: req_valid high in IDLE with credit -> grant and mem_valid high on next cycle; one IDLE cycle SHALL separate consecutive bursts.
REQ-029 In IDLE and REFILL mem_valid, req_ready and grant SHALL be 0; mem_port holds last value.
REQ-030 weight SHALL be sampled only in REFILL; changes at other times take effect at next refill.
REQ-031 Credit SHALL never underflow; a granted port always has credit >= 1.

Reset
REQ-032 sys_rst SHALL, synchronously and with priority over all other updates, set state IDLE, grant 0, mem_port 0, rr_ptr 0, all credits 1, all served_cnt 0.
REQ-033 Reset mid-burst SHALL abandon the burst without counting it; mem_valid SHALL be 0 the cycle after reset is sampled.

Structure
REQ-034 State encoding, counter width (32) and saturation constant SHALL live in shared package qos_pkg.
REQ-035 Round-robin first-one picker SHALL be sub-module rr_pick (inputs mask, ptr; output one-hot, index).

Verification
REQ-036 Reset then port 0 single-beat burst, mem_ready=1 -> mem_valid cycle 1, served_cnt[0]=1, rr_ptr=1.
REQ-037 All 4 ports continuously requesting 1-beat bursts, weights 1,1,1,1 -> grant order 0,1,2,3,REFILL,0,... .
REQ-038 Weights 3,1,0,0, ports 0,1 always valid -> per refill period port0 3 bursts, port1 1 burst.
REQ-039 Port 2 4-beat burst, mem_ready low 2 cycles mid-burst, port 3 valid throughout -> grant stays 2 until last beat, then port 3.
REQ-040 sys_rst asserted on beat 2 of a 4-beat burst -> grant 0, served_cnt 0, credits 1 next cycle.
REQ-041 served_cnt[1] forced near 0xFFFFFFFE, two more bursts -> holds 0xFFFFFFFF.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared types and constants for the QoS weighted round-robin arbiter.
package qos_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_BURST  = 2'd2
  } state_e;

  localparam int          CNT_W   = 32;
  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;
endpackage

// File: rtl/qos_wrr_arbiter_rr_pick.sv
// Round-robin first-one picker: first set bit of mask at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  int p;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    p      = 0;
    for (int k = 0; k < N; k++) begin
      p = (int'(ptr) + k) % N;
      if (!any && mask[p]) begin
        any       = 1'b1;
        onehot[p] = 1'b1;
        idx       = IW'(p);
      end
    end
  end
endmodule

// File: rtl/qos_wrr_arbiter.sv
// Credit-weighted round-robin burst arbiter: NPORTS requesters onto one memory port.
module qos_wrr_arbiter
  import qos_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int AW     = 32,
  parameter int WW     = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NPORTS-1:0]           req_valid,
  input  logic [NPORTS-1:0]           req_last,
  input  logic [NPORTS-1:0]           req_we,
  input  logic [NPORTS*AW-1:0]        req_addr,
  output logic [NPORTS-1:0]           req_ready,
  input  logic [NPORTS*WW-1:0]        weight,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [AW-1:0]               mem_addr,
  output logic                        mem_we,
  output logic [$clog2(NPORTS)-1:0]   mem_port,
  output logic [NPORTS-1:0]           grant,
  output logic [NPORTS*CNT_W-1:0]     served_cnt
);
  localparam int IW = $clog2(NPORTS);

  state_e            state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]     mem_port_q, mem_port_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NPORTS-1:0] elig, pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [AW-1:0]     addr_a [NPORTS];
  logic              burst, refill, hs, done;

  assign burst     = (state_q == ST_BURST);
  assign refill    = (state_q == ST_REFILL);
  assign mem_valid = burst & req_valid[mem_port_q];
  assign mem_addr  = addr_a[mem_port_q];
  assign mem_we    = req_we[mem_port_q];
  assign hs        = mem_valid & mem_ready;
  assign done      = hs & req_last[mem_port_q];
  assign req_ready = burst ? (grant_q & {NPORTS{mem_ready}}) : '0;
  assign grant     = grant_q;
  assign mem_port  = mem_port_q;

  rr_pick #(.N(NPORTS), .IW(IW)) u_pick (
    .mask   (elig),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    logic [WW-1:0]    credit_q, credit_d, wt;
    logic [CNT_W-1:0] served_q, served_d;

    assign wt        = weight[i*WW +: WW];
    assign addr_a[i] = req_addr[i*AW +: AW];
    assign elig[i]   = req_valid[i] & (credit_q != '0);
    assign served_cnt[i*CNT_W +: CNT_W] = served_q;

    always_comb begin
      credit_d = credit_q;
      served_d = served_q;
      if (refill) begin
        // A zero weight still earns one burst per period so no port starves.
        credit_d = (wt == '0) ? WW'(1) : wt;
      end else if (done && grant_q[i]) begin
        if (credit_q != '0) credit_d = credit_q - 1'b1;
        if (served_q != CNT_SAT) served_d = served_q + 1'b1;
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        credit_q <= WW'(1);
        served_q <= '0;
      end else begin
        credit_q <= credit_d;
        served_q <= served_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mem_port_d = mem_port_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_oh;
          mem_port_d = pick_idx;
          state_d    = ST_BURST;
        end else if (|req_valid) begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: state_d = ST_IDLE;
      ST_BURST: begin
        // Grant is held until the last beat; a dropped req_valid just stalls.
        if (done) begin
          grant_d  = '0;
          rr_ptr_d = (mem_port_q == IW'(NPORTS-1)) ? '0 : mem_port_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      mem_port_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mem_port_q <= mem_port_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// Directed bench for qos_wrr_arbiter (NPORTS=4, AW=32, WW=4).
module tb_qos_wrr_arbiter;
  import qos_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int WW = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [N-1:0]  req_valid, req_last, req_we, req_ready, grant;
  logic [N*AW-1:0] req_addr;
  logic [N*WW-1:0] weight;
  logic          mem_valid, mem_ready, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_port;
  logic [N*32-1:0] served_cnt;

  int checks = 0;
  int errors = 0;
  int log_q[$];
  int exp_q[$];

  always #5 sys_clk = ~sys_clk;

  qos_wrr_arbiter #(.NPORTS(N), .AW(AW), .WW(WW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .weight     (weight),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_port   (mem_port),
    .grant      (grant),
    .served_cnt (served_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] srv(input int i);
    return served_cnt[i*32 +: 32];
  endfunction

  function automatic logic [WW-1:0] cred(input int i);
    case (i)
      0: return dut.g_port[0].credit_q;
      1: return dut.g_port[1].credit_q;
      2: return dut.g_port[2].credit_q;
      default: return dut.g_port[3].credit_q;
    endcase
  endfunction

  task automatic do_reset();
    req_valid = '0;
    sys_rst   = 1'b1;
    step(2);
    sys_rst   = 1'b0;
  endtask

  // Log each burst's port (grant one-hot) and each REFILL cycle as 9.
  task automatic collect_chk(input string tag, input int n);
    log_q.delete();
    for (int c = 0; c < 80 && log_q.size() < n; c++) begin
      step(1);
      if (grant != '0) log_q.push_back(oh2idx(grant));
      else if (dut.state_q == ST_REFILL) log_q.push_back(9);
    end
    chk({tag, "_len"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(log_q.size() > i ? log_q[i] : -1), 64'(exp_q[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    sys_rst   = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_we    = '0;
    mem_ready = 1'b0;
    weight    = 16'h1111;
    req_addr  = {32'h3000_0003, 32'h2000_0002, 32'h1000_0001, 32'h0000_1000};
    step(2);

    // reset state
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_mem_valid", 64'(mem_valid), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_mem_port", 64'(mem_port), 64'h0);
    chk("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_served%0d", i), 64'(srv(i)), 64'h0);
      chk($sformatf("rst_credit%0d", i), 64'(cred(i)), 64'h1);
    end
    sys_rst = 1'b0;

    // port 0 single-beat burst
    req_valid = 4'b0001; req_last = 4'b1111; req_we = 4'b0001; mem_ready = 1'b1;
    #1 chk("t1_idle_mem_valid", 64'(mem_valid), 64'h0);
    step(1);
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_mem_valid", 64'(mem_valid), 64'h1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h1000);
    chk("t1_mem_we", 64'(mem_we), 64'h1);
    chk("t1_req_ready", 64'(req_ready), 64'h1);
    step(1);
    chk("t1_grant_clr", 64'(grant), 64'h0);
    chk("t1_served0", 64'(srv(0)), 64'h1);
    chk("t1_rr_ptr", 64'(dut.rr_ptr_q), 64'h1);
    chk("t1_mem_port_hold", 64'(mem_port), 64'h0);
    chk("t1_credit0", 64'(cred(0)), 64'h0);
    req_valid = '0;

    // equal weights, all ports requesting
    do_reset();
    weight = 16'h1111; req_valid = 4'b1111; req_last = 4'b1111; mem_ready = 1'b1;
    exp_q = '{0, 1, 2, 3, 9, 0, 1, 2, 3, 9};
    collect_chk("order_eq", 10);
    req_valid = '0;

    // weights 3,1,0,0 with ports 0,1 active
    do_reset();
    weight = {4'h0, 4'h0, 4'h1, 4'h3}; req_valid = 4'b0011;
    exp_q = '{0, 1, 9, 0, 1, 0, 0, 9, 1, 0, 0, 0, 9};
    collect_chk("order_w31", 13);
    req_valid = '0;
    step(1);
    chk("w31_credit0", 64'(cred(0)), 64'h3);
    chk("w31_credit1", 64'(cred(1)), 64'h1);
    chk("w31_credit2_zero_w", 64'(cred(2)), 64'h1);

    // port 2 four-beat burst with stall, port 3 waiting
    do_reset();
    weight = 16'h1111; req_valid = 4'b1100; req_last = 4'b1000; mem_ready = 1'b1;
    step(1);
    chk("t39_grant", 64'(grant), 64'h4);
    chk("t39_mem_port", 64'(mem_port), 64'h2);
    chk("t39_mem_addr", 64'(mem_addr), 64'h2000_0002);
    step(1);
    mem_ready = 1'b0;
    #1 chk("t39_stall_ready", 64'(req_ready), 64'h0);
    step(1);
    chk("t39_stall_grant", 64'(grant), 64'h4);
    chk("t39_stall_valid", 64'(mem_valid), 64'h1);
    step(1);
    mem_ready = 1'b1;
    step(2);
    chk("t39_mid_served2", 64'(srv(2)), 64'h0);
    chk("t39_mid_grant", 64'(grant), 64'h4);
    req_last = 4'b1100;
    step(1);
    chk("t39_done_grant", 64'(grant), 64'h0);
    chk("t39_served2", 64'(srv(2)), 64'h1);
    chk("t39_gap_valid", 64'(mem_valid), 64'h0);
    step(1);
    chk("t39_next_grant", 64'(grant), 64'h8);
    chk("t39_next_port", 64'(mem_port), 64'h3);
    step(1);
    chk("t39_served3", 64'(srv(3)), 64'h1);
    req_valid = '0;

    // reset on beat 2 of a port 1 four-beat burst
    req_valid = 4'b0010; req_last = 4'b0000; mem_ready = 1'b1;
    step(1);
    chk("t40_grant", 64'(grant), 64'h2);
    step(1);
    sys_rst = 1'b1;
    step(1);
    chk("t40_grant", 64'(grant), 64'h0);
    chk("t40_mem_valid", 64'(mem_valid), 64'h0);
    chk("t40_mem_port", 64'(mem_port), 64'h0);
    chk("t40_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t40_served%0d", i), 64'(srv(i)), 64'h0);
      chk($sformatf("t40_credit%0d", i), 64'(cred(i)), 64'h1);
    end
    sys_rst = 1'b0; req_valid = '0;

    // served counter saturation on port 1
    step(1);
    force dut.g_port[1].served_q = 32'hFFFF_FFFE;
    step(1);
    release dut.g_port[1].served_q;
    weight = 16'h1111; req_valid = 4'b0010; req_last = 4'b1111; mem_ready = 1'b1;
    step(2);
    chk("t41_first", 64'(srv(1)), 64'hFFFF_FFFF);
    step(4);
    chk("t41_sat", 64'(srv(1)), 64'hFFFF_FFFF);
    chk("t41_credit1", 64'(cred(1)), 64'h0);
    req_valid = '0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
